// File: rtl/minimumf_reduce_pkg.sv
// Shared definitions for the minimumf reduction stage.
//   FP32_QNAN      canonical quiet NaN produced whenever a NaN enters fmin
//   EXP_W, MANT_W  IEEE-754 single-precision field widths
//   state_t        reduction FSM states
//   fp32_is_nan    exponent all-ones with a non-zero mantissa
package minf_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam int          EXP_W     = 8;
  localparam int          MANT_W    = 23;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no partial result held
    ACCUM = 2'd1,  // acc holds the running minimum
    DONE  = 2'd2   // result held, waiting for the downstream handshake
  } state_t;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    return (v[MANT_W +: EXP_W] == '1) && (v[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/minimumf_reduce_fp32_min_cmp.sv
// Combinational IEEE-754-2019 minimum of two fp32 values, no flush-to-zero.
//   a, b : operands
//   y    : minimum; canonical qNaN if either operand is NaN, a on equal bits
// Sign-magnitude ordering makes infinities, subnormals and -0 < +0 fall out
// of a plain compare on the low 31 bits once the sign cases are split.
module fp32_min_cmp
  import minf_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic a_neg;
  logic b_neg;
  logic b_mag_lt;
  logic b_mag_gt;

  assign a_neg    = a[31];
  assign b_neg    = b[31];
  assign b_mag_lt = b[30:0] < a[30:0];
  assign b_mag_gt = b[30:0] > a[30:0];

  always_comb begin
    if (fp32_is_nan(a) || fp32_is_nan(b)) begin
      y = FP32_QNAN;
    end else if (a_neg != b_neg) begin
      y = a_neg ? a : b;
    end else if (!a_neg) begin
      // Both positive: smaller magnitude is the smaller value.
      y = b_mag_lt ? b : a;
    end else begin
      // Both negative: larger magnitude is the smaller value.
      y = b_mag_gt ? b : a;
    end
  end

endmodule

// File: rtl/minimumf_reduce.sv
// Streaming fp32 min-reduction with valid/ready handshakes on both sides.
// Consumes one element per cycle; each packet (closed by ins_last) yields one
// registered minimum and a saturating element count one cycle after the last
// element is accepted.
//   clk, rst                          clock, async active-low reset
//   ins, ins_last, ins_valid/ready    element stream
//   outs, outs_count, outs_valid/ready result stream
// DATA_TYPE must be 32 (IEEE-754 single).
module minimumf_reduce
  import minf_pkg::*;
#(
  parameter int DATA_TYPE   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_TYPE-1:0]   ins,
  input  logic                   ins_last,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic [DATA_TYPE-1:0]   outs,
  output logic [COUNT_WIDTH-1:0] outs_count,
  output logic                   outs_valid,
  input  logic                   outs_ready
);

  state_t                 state_q, state_d;
  logic [DATA_TYPE-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [DATA_TYPE-1:0]   min_y;
  logic                   ins_fire;
  logic                   out_fire;

  fp32_min_cmp u_min (
    .a (acc_q),
    .b (ins),
    .y (min_y)
  );

  // A held result only blocks the input while downstream is stalling it.
  assign ins_ready = (state_q != DONE) || outs_ready;
  assign ins_fire  = ins_valid && ins_ready;
  assign out_fire  = outs_valid && outs_ready;

  assign outs_valid = (state_q == DONE);
  assign outs       = acc_q;
  assign outs_count = count_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      EMPTY, DONE: begin
        // In DONE an accepted element implies outs_ready, so the result is
        // leaving this same cycle and the new packet starts without a bubble.
        if (ins_fire) begin
          acc_d   = ins;  // single-element packets pass through untouched
          count_d = COUNT_WIDTH'(1);
          state_d = ins_last ? DONE : ACCUM;
        end else if (state_q == DONE && out_fire) begin
          state_d = EMPTY;
        end
      end
      ACCUM: begin
        if (ins_fire) begin
          acc_d   = min_y;
          count_d = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);
          state_d = ins_last ? DONE : ACCUM;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_minimumf_reduce.sv
// Directed self-checking bench for minimumf_reduce. Two instances share the
// stimulus: the default 16-bit counter and a 4-bit counter for saturation.
module tb_minimumf_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_last;
  logic        ins_valid;
  logic        outs_ready;

  logic        ins_ready,  ins_ready4;
  logic [31:0] outs,       outs4;
  logic [15:0] outs_count;
  logic [3:0]  outs_count4;
  logic        outs_valid, outs_valid4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minimumf_reduce #(.DATA_TYPE(32), .COUNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_last   (ins_last),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_count (outs_count),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  minimumf_reduce #(.DATA_TYPE(32), .COUNT_WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_last   (ins_last),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready4),
    .outs       (outs4),
    .outs_count (outs_count4),
    .outs_valid (outs_valid4),
    .outs_ready (outs_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one input beat, then land 1 time unit after the active edge.
  task automatic drive(input logic [31:0] d, input logic last, input logic valid);
    ins       = d;
    ins_last  = last;
    ins_valid = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] val, input logic [15:0] cnt);
    check({tag, "_valid"}, {31'b0, outs_valid}, 32'd1);
    check({tag, "_outs"},  outs, val);
    check({tag, "_count"}, {16'b0, outs_count}, {16'b0, cnt});
  endtask

  initial begin
    rst        = 1'b0;
    ins        = 32'h0;
    ins_last   = 1'b0;
    ins_valid  = 1'b0;
    outs_ready = 1'b1;

    // Reset state
    #12;
    check("rst_valid", {31'b0, outs_valid}, 32'd0);
    check("rst_outs",  outs, 32'h0);
    check("rst_count", {16'b0, outs_count}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_ins_ready", {31'b0, ins_ready}, 32'd1);

    // 1: 3.0, -1.5, 2.0 -> -1.5
    drive(32'h4040_0000, 1'b0, 1'b1);
    check("t1_mid_valid", {31'b0, outs_valid}, 32'd0);
    drive(32'hBFC0_0000, 1'b0, 1'b1);
    drive(32'h4000_0000, 1'b1, 1'b1);
    expect_result("t1", 32'hBFC0_0000, 16'd3);
    idle();
    check("t1_drain_valid", {31'b0, outs_valid}, 32'd0);

    // 2: signed zeros, both orders
    drive(32'h0000_0000, 1'b0, 1'b1);
    drive(32'h8000_0000, 1'b1, 1'b1);
    expect_result("t2a", 32'h8000_0000, 16'd2);
    idle();
    drive(32'h8000_0000, 1'b0, 1'b1);
    drive(32'h0000_0000, 1'b1, 1'b1);
    expect_result("t2b", 32'h8000_0000, 16'd2);
    idle();

    // 3: sNaN in the packet yields canonical qNaN even against -inf
    drive(32'h3F80_0000, 1'b0, 1'b1);
    drive(32'h7F80_0001, 1'b0, 1'b1);
    drive(32'hFF80_0000, 1'b1, 1'b1);
    expect_result("t3", 32'h7FC0_0000, 16'd3);
    idle();

    // Both negative: -1.0, -3.0 -> -3.0; +inf vs 1.0 -> 1.0
    drive(32'hBF80_0000, 1'b0, 1'b1);
    drive(32'hC040_0000, 1'b1, 1'b1);
    expect_result("neg", 32'hC040_0000, 16'd2);
    idle();
    drive(32'h7F80_0000, 1'b0, 1'b1);
    drive(32'h3F80_0000, 1'b1, 1'b1);
    expect_result("inf", 32'h3F80_0000, 16'd2);
    idle();

    // Single-element NaN passes through with its payload intact
    drive(32'h7F80_0001, 1'b1, 1'b1);
    expect_result("nan1", 32'h7F80_0001, 16'd1);
    idle();

    // 4: back-pressure; the pending element's last flag must be ignored
    outs_ready = 1'b0;
    drive(32'h4120_0000, 1'b1, 1'b1);
    ins      = 32'h3F80_0000;
    ins_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      expect_result("t4_hold", 32'h4120_0000, 16'd1);
      check("t4_hold_ready", {31'b0, ins_ready}, 32'd0);
    end
    outs_ready = 1'b1;
    #1;
    check("t4_release_ready", {31'b0, ins_ready}, 32'd1);
    @(posedge clk);
    #1;
    expect_result("t4_next", 32'h3F80_0000, 16'd1);
    idle();
    check("t4_drain_valid", {31'b0, outs_valid}, 32'd0);

    // 5: 19 x 1.0 then -2.0 last; 4-bit counter saturates at 15
    for (int i = 0; i < 19; i++) drive(32'h3F80_0000, 1'b0, 1'b1);
    drive(32'hC000_0000, 1'b1, 1'b1);
    expect_result("t5_c16", 32'hC000_0000, 16'd20);
    check("t5_c4_outs",  outs4, 32'hC000_0000);
    check("t5_c4_count", {28'b0, outs_count4}, 32'd15);
    check("t5_c4_valid", {31'b0, outs_valid4}, 32'd1);
    idle();

    // 6: async reset mid-packet, then a clean packet
    drive(32'h3F80_0000, 1'b0, 1'b1);
    drive(32'h4000_0000, 1'b0, 1'b1);
    ins_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, outs_valid}, 32'd0);
    check("t6_rst_outs",  outs, 32'h0);
    check("t6_rst_count", {16'b0, outs_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    drive(32'h40A0_0000, 1'b1, 1'b1);
    expect_result("t6_after", 32'h40A0_0000, 16'd1);

    // Async reset while a result is held drops outs_valid immediately
    outs_ready = 1'b0;
    ins_valid  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6_done_rst_valid", {31'b0, outs_valid}, 32'd0);
    @(negedge clk);
    rst        = 1'b1;
    outs_ready = 1'b1;
    idle();
    check("t6_idle_valid", {31'b0, outs_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minimumf_reduce.md
Name: minimumf_reduce

Overview:
- Streaming reduction stage placed directly downstream of the elementwise minimumf unit.
- Consumes a packet of fp32 values delimited by a last flag and emits one fp32 minimum per packet, plus the packet element count.
- Uses the dataflow valid/ready handshake, so it drops into the elastic circuit like any other arith unit.
- Throughput: one element per cycle. Latency: one cycle from acceptance of the last element to the result.

Parameters:
- DATA_TYPE, 32, data width. Only 32 (IEEE-754 single) is legal.
- COUNT_WIDTH, 16, width of the saturating element counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ins  in  DATA_TYPE  input element
- ins_last  in  1  marks the final element of a packet; qualified by ins_valid
- ins_valid  in  1  input valid
- ins_ready  out  1  input ready
- outs  out  DATA_TYPE  packet minimum
- outs_count  out  COUNT_WIDTH  number of elements in the packet (saturating)
- outs_valid  out  1  result valid
- outs_ready  in  1  downstream ready

Behaviour:
- One clock; reset is asynchronous and active-low on rst. All registers clear immediately on rst=0.
- Reset values: state=EMPTY, acc=0, count=0, outs=0, outs_count=0, outs_valid=0.
  - ins_ready=1 from the first cycle after rst deasserts.
- States:
  - EMPTY: no partial result held.
  - ACCUM: acc holds the running minimum.
  - DONE: result held.
- Handshakes:
  - ins_fire = ins_valid & ins_ready.
  - out_fire = outs_valid & outs_ready.
- Outputs: outs_valid = (state==DONE); outs = acc; outs_count = count.
  - Both are registered, with no combinational path from ins to outs.
- ins_ready = (state!=DONE) | outs_ready. Stalls only while a result waits on back-pressure.
- EMPTY, on ins_fire:
  - acc <= ins; count <= 1.
  - Next state is DONE if ins_last, else ACCUM.
- ACCUM, on ins_fire:
  - acc <= fmin(acc, ins); count <= sat(count+1).
  - Next state is DONE if ins_last, else ACCUM.
- ACCUM with no ins_fire: hold.
- DONE:
  - Hold outs and outs_count stable while outs_ready=0. ins_ready=0 in that case.
  - out_fire with no ins_fire: go to EMPTY.
  - out_fire and ins_fire in the same cycle: handle as EMPTY-acceptance of ins, with no bubble. Back-to-back single-element packets give one result per cycle.
- Saturation: count stops at 2^COUNT_WIDTH-1 and never wraps.
- fmin(a,b), IEEE-754-2019 minimum semantics, no flush-to-zero:
  - NaN is exp==0xFF with mant!=0.
  - If either operand is NaN, the result is the canonical qNaN 0x7FC00000. NaN is therefore sticky for the rest of the packet.
  - If the signs differ, the negative operand wins. So -0.0 (0x80000000) < +0.0.
  - Both positive: the smaller magnitude bits win.
  - Both negative: the larger magnitude bits win.
  - Equal bits: return a.
  - Infinities and subnormals fall out of the bitwise ordering.
- A single-element packet has outs = ins unmodified, including a non-canonical NaN payload, because fmin is not applied.
- Reset mid-packet: the partial result is discarded and outs_valid drops asynchronously. The next packet starts clean.
- ins_last on an element that is not accepted has no effect.

Decomposition:
- Shared package minf_pkg:
  - FP32_QNAN = 32'h7FC00000.
  - Field widths: EXP_W=8, MANT_W=23.
  - State enum {EMPTY, ACCUM, DONE}.
- One combinational sub-module, fp32_min_cmp (inputs a, b; output y). It implements fmin and can be reused by a future pipelined minimumf.

Test Plan:
1. Packet 0x40400000 (3.0), 0xBFC00000 (-1.5), 0x40000000 (2.0, last) accepted on consecutive cycles -> outs=0xBFC00000, outs_count=3, outs_valid=1 in the cycle after the last element is accepted.
2. Packet +0.0 then -0.0(last) -> outs=0x80000000. Packet -0.0 then +0.0(last) -> outs=0x80000000.
3. Packet 0x3F800000, 0x7F800001 (sNaN), 0xFF800000 (-inf, last) -> outs=0x7FC00000, count=3.
4. Back-pressure:
   - Single-element packet 0x41200000, then outs_ready=0 for 5 cycles -> outs and outs_valid stable, ins_ready=0.
   - Then outs_ready=1 with ins_valid=1 (0x3F800000, last) -> both handshakes fire in one cycle.
   - Next cycle: outs=0x3F800000, count=1.
5. COUNT_WIDTH=4, 20-element packet of 1.0 with the last element -2.0 -> outs=0xC0000000, outs_count=15 (saturated).
6. Drive rst=0 asynchronously, mid-cycle, after 2 elements of a packet:
   - outs_valid=0 without waiting for a clock edge.
   - After release, packet 5.0 (last) -> outs=0x40A00000, count=1.
